fetch_queue: RTL

Instruction fetch queue between the PC/fetch stage and the decode stage of the pipelined CPU. Each cycle it captures the fetched `{pc, instr}` pair and buffers up to `DEPTH` entries. It presents the oldest entry to decode over a valid/ready handshake and drives the `steve` advance-enable back to the PC stage. On a taken branch it flushes all buffered (wrong-path) instructions.

---
 rtl/cpu_pkg.sv | 15 +
 rtl/fetch_queue_mem.sv | 28 ++
 rtl/fetch_queue.sv | 95 +++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath width, reset PC, NOP encoding and the
// fetch-queue payload layout.
package cpu_pkg;

  localparam int unsigned WORD_W = 32;

  localparam logic [WORD_W-1:0] RESET_PC  = 32'h0040_001c;
  localparam logic [WORD_W-1:0] NOP_INSTR = 32'h0000_0000;

  typedef struct packed {
    logic [WORD_W-1:0] pc;
    logic [WORD_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue_mem.sv
// Storage for fetch_queue: DEPTH x fetch_entry_t register array.
// Ports: clk, we/waddr/wdata (synchronous write), raddr/rdata
// (asynchronous read). No reset; the owner masks stale contents.
module fetch_queue_mem
  import cpu_pkg::*;
#(
  parameter int unsigned DEPTH  = 2,
  parameter int unsigned PTR_W  = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [PTR_W-1:0] waddr,
  input  fetch_entry_t     wdata,
  input  logic [PTR_W-1:0] raddr,
  output fetch_entry_t     rdata
);

  fetch_entry_t mem [DEPTH];

  // Single write port.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Asynchronous read of the addressed entry.
  assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch queue between the PC stage and decode.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   in_valid/in_pc/in_instr  fetched entry from the PC stage
//   flush                 taken branch: drop queued and incoming entries
//   steve                 PC stage may advance (queue not full)
//   out_valid/out_pc/out_instr/out_ready  head entry handshake to decode
//   count                 number of buffered entries
//   misalign              sticky flag: an accepted PC was not word aligned
module fetch_queue
  import cpu_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  input  logic [WORD_W-1:0]          in_pc,
  input  logic [WORD_W-1:0]          in_instr,
  input  logic                       flush,
  output logic                       steve,
  output logic                       out_valid,
  output logic [WORD_W-1:0]          out_pc,
  output logic [WORD_W-1:0]          out_instr,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       misalign
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] cnt_q;
  logic             misalign_q;
  logic             push;
  logic             pop;
  fetch_entry_t     wr_entry;
  fetch_entry_t     head;

  // Handshake qualifiers; flush suppresses both sides.
  assign push = in_valid && steve && !flush;
  assign pop  = out_valid && out_ready && !flush;

  assign wr_entry = '{pc: in_pc, instr: in_instr};

  fetch_queue_mem #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (wr_entry),
    .raddr (rd_ptr),
    .rdata (head)
  );

  // Pointer and occupancy tracking; count is kept apart from the pointers so
  // full and empty are distinguishable.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + CNT_W'(1);
        2'b01:   cnt_q <= cnt_q - CNT_W'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Sticky misalignment flag; only reset clears it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      misalign_q <= 1'b0;
    end else if (push && (in_pc[1:0] != 2'b00)) begin
      misalign_q <= 1'b1;
    end
  end

  // All outputs derive from registered state only; head masked when empty.
  assign count     = cnt_q;
  assign misalign  = misalign_q;
  assign steve     = (cnt_q < CNT_W'(DEPTH));
  assign out_valid = (cnt_q != '0);
  assign out_pc    = out_valid ? head.pc    : '0;
  assign out_instr = out_valid ? head.instr : NOP_INSTR;

endmodule
